// File: rtl/dual_xor_cfg_pkg.sv
// Frame layout and FSM encoding for the dual XOR cipher configuration chain,
// used by the receiver RTL and by the stimulus side.
package dual_xor_cfg_pkg;

  function automatic int cfg_len(input int m);
    return 4 * m + 2;
  endfunction

  function automatic int MUX_EXT_A_BIT(input int m);
    return 4 * m + 1;
  endfunction

  function automatic int MUX_EN_D_BIT(input int m);
    return 4 * m;
  endfunction

  function automatic int TX_TAPS_LSB(input int m);
    return 3 * m;
  endfunction

  function automatic int TX_STATE_LSB(input int m);
    return 2 * m;
  endfunction

  function automatic int RX_TAPS_LSB(input int m);
    return m;
  endfunction

  function automatic int RX_STATE_LSB();
    return 0;
  endfunction

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } cfg_rx_state_t;

endpackage

// File: rtl/dual_xor_cfg_rx_shift.sv
// Shadow shift register plus saturating frame-length counter for the config receiver.
module cfg_shift_reg #(
  parameter int N  = 130,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_en,
  input  logic          start,
  input  logic          cfg_i,
  output logic [N-1:0]  shadow,
  output logic [CW-1:0] cnt,
  output logic          overrun
);

  localparam logic [CW-1:0] SAT = CW'(N + 1);

  logic [N-1:0]  shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (shift_en) begin
      shadow_d = {cfg_i, shadow_q[N-1:1]};
      if (start)              cnt_d = CW'(1);
      else if (cnt_q != SAT)  cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign shadow  = shadow_q;
  assign cnt     = cnt_q;
  // Counter parks at N+1 so any frame longer than N stays distinguishable.
  assign overrun = (cnt_q == SAT);

endmodule

// File: rtl/dual_xor_cfg_rx.sv
// Config chain receiver: captures LSB-first frames, commits on exact length.
// Optional macro DUAL_XOR_CFG_RX_LOCKUP_CHECK_EN also rejects all-zero LFSR seeds.
module dual_xor_cfg_rx
  import dual_xor_cfg_pkg::*;
#(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_en,
  input  logic         cfg_i,
  output logic         cfg_o,
  output logic         mux_ext_a,
  output logic         mux_en_d,
  output logic [M-1:0] tx_lfsr_taps,
  output logic [M-1:0] tx_lfsr_state,
  output logic [M-1:0] rx_lfsr_taps,
  output logic [M-1:0] rx_lfsr_state,
  output logic         cfg_load,
  output logic         cfg_valid,
  output logic         cfg_err
);

  localparam int N   = cfg_len(M);
  localparam int CW  = $clog2(N + 2);
  localparam int EXT = MUX_EXT_A_BIT(M);
  localparam int END = MUX_EN_D_BIT(M);
  localparam int TXT = TX_TAPS_LSB(M);
  localparam int TXS = TX_STATE_LSB(M);
  localparam int RXT = RX_TAPS_LSB(M);
  localparam int RXS = RX_STATE_LSB();

  cfg_rx_state_t state_q, state_d;
  logic [N-1:0]  active_q, active_d;
  logic          load_q, load_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic [N-1:0]  shadow;
  logic [CW-1:0] cnt;
  logic          overrun;
  logic          start;
  logic          seeds_ok;
  logic          frame_ok;

  cfg_shift_reg #(.N(N), .CW(CW)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (cfg_en),
    .start    (start),
    .cfg_i    (cfg_i),
    .shadow   (shadow),
    .cnt      (cnt),
    .overrun  (overrun)
  );

`ifdef DUAL_XOR_CFG_RX_LOCKUP_CHECK_EN
  assign seeds_ok = (shadow[TXS +: M] != '0) && (shadow[RXS +: M] != '0);
`else
  assign seeds_ok = 1'b1;
`endif

  assign frame_ok = (cnt == CW'(N)) && !overrun && seeds_ok;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    load_d   = 1'b0;
    valid_d  = valid_q;
    err_d    = err_q;
    start    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_en) begin
          state_d = S_SHIFT;
          start   = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        // Falling cfg_en is the only frame terminator; the frame is judged here.
        if (!cfg_en) begin
          state_d = S_IDLE;
          if (frame_ok) begin
            active_d = shadow;
            load_d   = 1'b1;
            valid_d  = 1'b1;
          end else begin
            err_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      load_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      load_q   <= load_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign cfg_o         = shadow[0];
  assign mux_ext_a     = active_q[EXT];
  assign mux_en_d      = active_q[END];
  assign tx_lfsr_taps  = active_q[TXT +: M];
  assign tx_lfsr_state = active_q[TXS +: M];
  assign rx_lfsr_taps  = active_q[RXT +: M];
  assign rx_lfsr_state = active_q[RXS +: M];
  assign cfg_load      = load_q;
  assign cfg_valid     = valid_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_dual_xor_cfg_rx.sv
// Directed frame table for the config receiver, plus a mid-frame reset sequence.
module tb_dual_xor_cfg_rx;
  import dual_xor_cfg_pkg::*;

  localparam int M   = 32;
  localparam int N   = cfg_len(M);
  localparam int EXT = MUX_EXT_A_BIT(M);
  localparam int END = MUX_EN_D_BIT(M);
  localparam int TXT = TX_TAPS_LSB(M);
  localparam int TXS = TX_STATE_LSB(M);
  localparam int RXT = RX_TAPS_LSB(M);
  localparam int RXS = RX_STATE_LSB();

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_en = 1'b0;
  logic cfg_i = 1'b0;
  logic cfg_o, mux_ext_a, mux_en_d, cfg_load, cfg_valid, cfg_err;
  logic [M-1:0] tx_lfsr_taps, tx_lfsr_state, rx_lfsr_taps, rx_lfsr_state;

  always #5 clk = ~clk;

  dual_xor_cfg_rx #(.M(M)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_en        (cfg_en),
    .cfg_i         (cfg_i),
    .cfg_o         (cfg_o),
    .mux_ext_a     (mux_ext_a),
    .mux_en_d      (mux_en_d),
    .tx_lfsr_taps  (tx_lfsr_taps),
    .tx_lfsr_state (tx_lfsr_state),
    .rx_lfsr_taps  (rx_lfsr_taps),
    .rx_lfsr_state (rx_lfsr_state),
    .cfg_load      (cfg_load),
    .cfg_valid     (cfg_valid),
    .cfg_err       (cfg_err)
  );

  typedef struct {
    string        name;
    logic [N-1:0] data;
    int           len;
    logic         exp_ok;
  } vec_t;

  int passed = 0;
  int total  = 0;

  logic [N-1:0] exp_act = '0;
  logic [N-1:0] exp_sh  = '0;
  logic         exp_valid = 1'b0;
  logic [N-1:0] rb;

  function automatic logic [N-1:0] mk(input logic ext, input logic en_d,
                                      input logic [M-1:0] txt, input logic [M-1:0] txs,
                                      input logic [M-1:0] rxt, input logic [M-1:0] rxs);
    return {ext, en_d, txt, txs, rxt, rxs};
  endfunction

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_outputs(input string nm);
    chk({nm, ".mux_ext_a"}, N'(mux_ext_a), N'(exp_act[EXT]));
    chk({nm, ".mux_en_d"},  N'(mux_en_d),  N'(exp_act[END]));
    chk({nm, ".tx_taps"},   N'(tx_lfsr_taps),  N'(exp_act[TXT +: M]));
    chk({nm, ".tx_state"},  N'(tx_lfsr_state), N'(exp_act[TXS +: M]));
    chk({nm, ".rx_taps"},   N'(rx_lfsr_taps),  N'(exp_act[RXT +: M]));
    chk({nm, ".rx_state"},  N'(rx_lfsr_state), N'(exp_act[RXS +: M]));
    chk({nm, ".valid"},     N'(cfg_valid), N'(exp_valid));
  endtask

  task automatic send_frame(input string nm, input logic [N-1:0] d, input int len,
                            input logic ok);
    logic [N-1:0] old_sh;
    int loads;
    old_sh = exp_sh;
    loads  = 0;
    rb     = '0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i < N) rb[i] = cfg_o;
      if (cfg_load) loads++;
      if (i == 1) chk({nm, ".err_clear"}, N'(cfg_err), '0);
      cfg_en = 1'b1;
      cfg_i  = (i < N) ? d[i] : 1'b1;
      exp_sh = {cfg_i, exp_sh[N-1:1]};
    end
    @(negedge clk);
    if (cfg_load) loads++;
    cfg_en = 1'b0;
    cfg_i  = 1'b0;
    chk({nm, ".no_early_load"}, N'(loads), '0);
    if (len >= N) chk({nm, ".readback"}, rb, old_sh);
    @(negedge clk);
    if (ok) begin
      exp_act   = d;
      exp_valid = 1'b1;
    end
    chk({nm, ".load"}, N'(cfg_load), N'(ok));
    chk({nm, ".err"},  N'(cfg_err),  N'(!ok));
    chk_outputs(nm);
    @(negedge clk);
    chk({nm, ".load_off"}, N'(cfg_load), '0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"nominal", mk(1'b0, 1'b0, 32'h48000000, 32'h77000000, 32'h48000000, 32'h77000000), N, 1'b1};
    vecs[1] = '{"frame_b", mk(1'b1, 1'b0, 32'hA5A5A5A5, 32'h12345678, 32'h0F0F0F0F, 32'hDEADBEEF), N, 1'b1};
    vecs[2] = '{"short",   mk(1'b1, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444), N-1, 1'b0};
    vecs[3] = '{"after_short", mk(1'b0, 1'b1, 32'hCAFEF00D, 32'h00000001, 32'h80000000, 32'h0000FFFF), N, 1'b1};
    vecs[4] = '{"overrun", mk(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), N+1, 1'b0};
`ifdef DUAL_XOR_CFG_RX_LOCKUP_CHECK_EN
    vecs[5] = '{"rx_seed0", mk(1'b1, 1'b0, 32'h48000000, 32'h77000000, 32'h48000000, 32'h00000000), N, 1'b0};
    vecs[6] = '{"tx_seed0", mk(1'b0, 1'b1, 32'h48000000, 32'h00000000, 32'h48000000, 32'h77000000), N, 1'b0};
`else
    vecs[5] = '{"rx_seed0", mk(1'b1, 1'b0, 32'h48000000, 32'h77000000, 32'h48000000, 32'h00000000), N, 1'b1};
    vecs[6] = '{"tx_seed0", mk(1'b0, 1'b1, 32'h48000000, 32'h00000000, 32'h48000000, 32'h77000000), N, 1'b1};
`endif
    vecs[7] = '{"final", mk(1'b1, 1'b1, 32'h0BADCAFE, 32'h13579BDF, 32'h2468ACE0, 32'hFEDCBA98), N, 1'b1};

    @(negedge clk);
    @(negedge clk);
    chk("reset.cfg_o",   N'(cfg_o),    '0);
    chk("reset.load",    N'(cfg_load), '0);
    chk("reset.err",     N'(cfg_err),  '0);
    chk_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[k]) begin
      send_frame(vecs[k].name, vecs[k].data, vecs[k].len, vecs[k].exp_ok);
      @(negedge clk);
    end

    // Reset arrives partway through a frame: everything clears at once.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cfg_en = 1'b1;
      cfg_i  = vecs[1].data[i];
    end
    @(negedge clk);
    rst    = 1'b1;
    cfg_en = 1'b0;
    #1;
    exp_act   = '0;
    exp_sh    = '0;
    exp_valid = 1'b0;
    chk("midreset.cfg_o", N'(cfg_o),    '0);
    chk("midreset.load",  N'(cfg_load), '0);
    chk("midreset.err",   N'(cfg_err),  '0);
    chk_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame("post_reset", vecs[0].data, N, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dual_xor_cfg_rx.md
# dual_xor_cfg_rx

Receiving end of the dual XOR cipher's serial configuration chain. Captures the LSB-first bit stream driven on `cfg_en`/`cfg_i` by the configuration stimulus, counts the frame length, and on frame end commits the shadow register to the active register. The active register holds the mux controls and the TX/RX LFSR taps and seeds. Readback is available via `cfg_o`, and the cipher core gets a one-cycle load strobe.

## Interface
- `M`, 32, LFSR width; frame length N = 4*M+2 bits
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_en`  in  1  frame enable; high for exactly N consecutive cycles per frame
- `cfg_i`  in  1  serial config data, LSB of frame first
- `cfg_o`  out  1  serial readback = shadow[0]
- `mux_ext_a`  out  1  committed frame bit N-1
- `mux_en_d`  out  1  committed frame bit N-2
- `tx_lfsr_taps`  out  M  committed bits [4M-1:3M]
- `tx_lfsr_state`  out  M  committed bits [3M-1:2M]
- `rx_lfsr_taps`  out  M  committed bits [2M-1:M]
- `rx_lfsr_state`  out  M  committed bits [M-1:0]
- `cfg_load`  out  1  one-cycle strobe on successful commit
- `cfg_valid`  out  1  sticky: at least one frame committed since reset
- `cfg_err`  out  1  last frame rejected

## Operation
- Shadow register: N bits. Every cycle with `cfg_en`=1 it updates as shadow <= {cfg_i, shadow[N-1:1]}. After N shifts, the first bit received sits in shadow[0].
- Bit counter: width clog2(N+2). Saturates at N+1, which marks an overrun.
- FSM states: S_IDLE, S_SHIFT.
  - S_IDLE, `cfg_en`=1: go to S_SHIFT. Counter <= 1 and the first bit shifts in the same edge. `cfg_err` clears.
  - S_SHIFT, `cfg_en`=1: stay in S_SHIFT and increment the counter (saturating).
  - S_SHIFT, `cfg_en`=0: go to S_IDLE and evaluate the frame.
- Frame evaluation:
  - Accept when counter == N. Active <= shadow, `cfg_load` <= 1, `cfg_valid` <= 1.
  - Reject in every other case, including short frames and overruns. Active register unchanged, `cfg_err` <= 1, `cfg_load` stays 0.
- `cfg_o` is combinational from shadow[0]. During a frame, the previous shadow contents stream back out, one bit per cycle.
- Reset mid-frame: all state clears immediately. A frame in progress is discarded. Reset is never treated as frame end.

## Timing
- Reset values:
  - Shadow register, active register, counter: all 0.
  - `cfg_o`, `cfg_load`, `cfg_valid`, `cfg_err`: all 0.
  - State: S_IDLE.
- Edges numbered 1..N each sample `cfg_en`=1.
- Edge N+1 samples `cfg_en`=0. After it, the active outputs carry the new values and `cfg_load`=1.
- `cfg_load` returns to 0 after edge N+2, so it is exactly one cycle wide.
- Latency from the last data bit sampled to the committed outputs: 1 cycle.
- Back-to-back frames: `cfg_en` must be low for at least 1 cycle between frames. A frame that keeps `cfg_en` high past N bits overruns and is rejected.

## Configuration
- Macro: `DUAL_XOR_CFG_RX_LOCKUP_CHECK_EN`.
- Defined: accept additionally requires `tx_lfsr_state`≠0 and `rx_lfsr_state`≠0 in the shadow register, since an all-zero seed locks up the LFSR. A frame failing this check is rejected with `cfg_err`=1.
- Undefined: length check only. An all-zero seed is committed as received.

## Structure
- Shared package `dual_xor_cfg_pkg` holds:
  - Function `cfg_len(M)` = 4*M+2.
  - Field offset functions: MUX_EXT_A_BIT, MUX_EN_D_BIT, TX_TAPS_LSB, TX_STATE_LSB, RX_TAPS_LSB, RX_STATE_LSB.
  - FSM state enum `cfg_rx_state_t`.
- The stimulus side uses the same package, so the frame layout is defined in one place.
- One sub-module: `cfg_shift_reg`, containing the shadow register, bit counter and overrun flag. The FSM, the commit logic and the active register stay in the top module.

## Test plan
All scenarios use M=32 (N=130).
- Nominal frame: send {0,0,tx_taps=0x48000000, tx_state=0x77000000, rx_taps=0x48000000, rx_state=0x77000000} LSB first with `cfg_en` high for 130 cycles. Required: fields match exactly, `cfg_load` high for exactly 1 cycle, 1 cycle after `cfg_en` falls, `cfg_valid`=1.
- Readback: send frame A, then frame B. Required: during frame B, `cfg_o` reproduces frame A bit by bit, LSB first.
- Short frame: `cfg_en` high for 129 cycles. Required: `cfg_err`=1, no `cfg_load`, outputs keep their previous values. A following 130-bit frame clears `cfg_err` and commits.
- Overrun: `cfg_en` high for 131 cycles. Required: `cfg_err`=1, outputs unchanged.
- Reset at bit 60 of a frame. Required: all outputs 0 immediately. A subsequent full frame commits normally.
- Lockup check, macro defined: frame with rx_state=0. Required: `cfg_err`=1, no commit. With the macro undefined, the same frame commits with rx_lfsr_state=0.
